// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the 1011 detector: a small word FIFO behind a
// valid/ready port, drained by a bit_en-paced shifter that emits gap-free bits.
module serial_bit_feeder #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       bit_en,
    output logic                       outbits,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int BL_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [BL_W-1:0]  LAST_IDX = BL_W'(DATA_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_n;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [DATA_W-1:0]  shreg, shreg_n;
    logic [BL_W-1:0]    bits_left, bits_left_n;
    logic               outbits_n, out_valid_n;
    logic               push, pop;
    logic [DATA_W-1:0]  head;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    assign in_ready = !reset && (fifo_count < FULL_CNT);
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    assign busy     = (state == SHIFT) || (fifo_count != '0);

    always_comb begin
        // NOTE: every output of this block gets a hold default first; without it a path that skips an assignment infers a latch.
        state_n     = state;
        shreg_n     = shreg;
        bits_left_n = bits_left;
        outbits_n   = outbits;
        out_valid_n = out_valid;
        pop         = 1'b0;
        if (bit_en) begin
            if (state == SHIFT && bits_left != '0) begin
                outbits_n   = first_bit(shreg);
                shreg_n     = advance(shreg);
                bits_left_n = bits_left - BL_W'(1);
            end else if (fifo_count != '0) begin
                pop         = 1'b1;
                outbits_n   = first_bit(head);
                shreg_n     = advance(head);
                bits_left_n = LAST_IDX;
                out_valid_n = 1'b1;
                state_n     = SHIFT;
            end else begin
                outbits_n   = IDLE_BIT;
                out_valid_n = 1'b0;
                state_n     = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bits_left <= '0;
            outbits   <= IDLE_BIT;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bits_left <= bits_left_n;
            outbits   <= outbits_n;
            out_valid <= out_valid_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    // NOTE: the storage array is not reset; an entry is only read after the count says it was written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: directed scenarios plus random traffic, both
// checked every cycle against a word-queue model of the feeder.
module tb_serial_bit_feeder;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              bit_en;
    logic              in_ready,   in_ready_l;
    logic              outbits,    outbits_l;
    logic              out_valid,  out_valid_l;
    logic [2:0]        fifo_count, fifo_count_l;
    logic              busy,       busy_l;

    serial_bit_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .bit_en(bit_en), .outbits(outbits), .out_valid(out_valid), .fifo_count(fifo_count), .busy(busy)
    );

    serial_bit_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
        .bit_en(bit_en), .outbits(outbits_l), .out_valid(out_valid_l), .fifo_count(fifo_count_l), .busy(busy_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Model: queue of buffered words, plus the word being emitted and which bit of it is on the line.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] cur;
    int                idx;
    bit                act;

    task automatic model_edge(input bit rst, input bit v, input logic [DATA_W-1:0] d,
                              input bit en, output bit acc);
        bit rdy;
        rdy = !rst && (q.size() < DEPTH);
        acc = v && rdy;
        if (rst) begin
            q.delete();
            act = 0;
            idx = 0;
            acc = 0;
        end else begin
            if (en) begin
                if (act && idx < DATA_W - 1) idx++;
                else if (q.size() > 0) begin
                    cur = q.pop_front();
                    idx = 0;
                    act = 1;
                end else act = 0;
            end
            if (acc) q.push_back(d);
        end
    endtask

    task automatic compare(input bit rst);
        check("outbits",      outbits,      act ? cur[DATA_W-1-idx] : 1'b0);
        check("out_valid",    out_valid,    act);
        check("fifo_count",   fifo_count,   q.size());
        check("in_ready",     in_ready,     !rst && (q.size() < DEPTH));
        check("busy",         busy,         act || (q.size() != 0));
        check("lsb_outbits",  outbits_l,    act ? cur[idx] : 1'b1);
        check("lsb_valid",    out_valid_l,  act);
        check("lsb_count",    fifo_count_l, q.size());
    endtask

    task automatic cycle(input bit rst, input bit v, input logic [DATA_W-1:0] d,
                         input bit en, output bit acc);
        reset    = rst;
        in_valid = v;
        in_data  = d;
        bit_en   = en;
        @(posedge clk);
        model_edge(rst, v, d, en, acc);
        @(negedge clk);
        compare(rst);
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while ((act || q.size() != 0) && n < 100) begin
            cycle(0, 0, '0, 1, acc);
            n++;
        end
        check("drain_idle", busy, 0);
    endtask

    bit                acc;
    logic [15:0]       col, col_l;
    int                cnt, peak, widx, n_en;
    logic [DATA_W-1:0] words [5];
    bit                pend_v;
    logic [DATA_W-1:0] pend_d;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; bit_en = 1'b0;
        cycle(1, 0, '0, 0, acc);
        cycle(1, 0, '0, 1, acc);
        cycle(0, 0, '0, 1, acc);

        // Single word 8'hB0, full-rate bit_en.
        cycle(0, 1, 8'hB0, 1, acc);
        col = '0; col_l = '0; cnt = 0;
        for (int i = 0; i < DATA_W; i++) begin
            cycle(0, 0, '0, 1, acc);
            col      = {col[14:0], outbits};
            col_l[i] = outbits_l;
            if (out_valid) cnt++;
        end
        check("b0_msb_bits", col[7:0], 8'hB0);
        check("b0_lsb_bits", col_l[7:0], 8'hB0);
        check("b0_valid_cycles", cnt, 8);
        cycle(0, 0, '0, 1, acc);
        check("b0_idle_after", out_valid, 0);

        // Two words back to back: 16 contiguous bits.
        peak = 0;
        cycle(0, 1, 8'h5B, 1, acc);
        if (fifo_count > peak) peak = fifo_count;
        col = '0; col_l = '0; cnt = 0;
        cycle(0, 1, 8'hB5, 1, acc);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) cycle(0, 0, '0, 1, acc);
            if (fifo_count > peak) peak = fifo_count;
            col      = {col[14:0], outbits};
            col_l[i] = outbits_l;
            if (out_valid) cnt++;
        end
        check("pair_msb_bits", col, 16'h5BB5);
        check("pair_lsb_bits", col_l, 16'hB55B);
        check("pair_contiguous", cnt, 16);
        check("pair_peak_count", peak, 1);
        drain();

        // Fill with bit_en low; fifth word must wait for a pop.
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        widx = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, words[widx], 0, acc);
            if (acc) widx++;
        end
        check("full_accepted", widx, 4);
        check("full_ready", in_ready, 0);
        n_en = 0;
        while (widx < 5 && n_en < 20) begin
            cycle(0, 1, words[widx], 1, acc);
            n_en++;
            if (acc) widx++;
        end
        check("fifth_accept_cycle", n_en, 2);
        drain();

        // Half-rate bit_en: each bit held two cycles.
        cycle(0, 1, 8'hB0, 1, acc);
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            cycle(0, 0, '0, (i % 2) == 1, acc);
            if (out_valid) cnt++;
        end
        check("half_rate_valid_cycles", cnt, 16);
        drain();

        // Reset mid-word with two words queued.
        cycle(0, 1, 8'hFF, 1, acc);
        cycle(0, 1, 8'hFF, 1, acc);
        cycle(0, 1, 8'hFF, 1, acc);
        cycle(0, 0, '0, 1, acc);
        check("pre_reset_queued", fifo_count, 2);
        cycle(1, 0, '0, 1, acc);
        check("reset_idle_bit", outbits, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, '0, 1, acc);
            if (out_valid) cnt++;
        end
        check("post_reset_valid", cnt, 0);

        // LSB-first instance on 8'h0D.
        cycle(0, 1, 8'h0D, 1, acc);
        col_l = '0;
        for (int i = 0; i < DATA_W; i++) begin
            cycle(0, 0, '0, 1, acc);
            col_l[i] = outbits_l;
        end
        check("lsb_0d_bits", col_l[7:0], 8'h0D);
        drain();

        // Random traffic with a holding source and varying bit rate.
        pend_v = 0;
        pend_d = '0;
        for (int i = 0; i < 3000; i++) begin
            int  en_pct;
            bit  rst;
            en_pct = (i / 500) % 3 == 0 ? 95 : ((i / 500) % 3 == 1 ? 25 : 65);
            if (!pend_v && $urandom_range(0, 99) < 55) begin
                pend_v = 1;
                pend_d = DATA_W'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            cycle(rst, pend_v, pend_d, $urandom_range(0, 99) < en_pct, acc);
            if (acc) pend_v = 0;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Upstream stage for the 1011 sequence detector.
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Shifts the words out one bit per enabled cycle on outbits, which drives the detector's serial input.
- Back-to-back words stream with no bubble; when no data is available the line idles at a fixed level.

Parameters:
- DATA_W, 8, width of each parallel input word.
- DEPTH, 4, FIFO depth in words; power of two, at least 2.
- MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first.
- IDLE_BIT, 0, level driven on outbits when not shifting.

Ports:
- clk  input  1  clock, all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  parallel word to serialise.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a word this cycle.
- bit_en  input  1  serial rate tick; the shifter advances only on edges where bit_en=1.
- outbits  output  1  registered serial bit to the detector.
- out_valid  output  1  outbits carries a data bit (not idle fill).
- fifo_count  output  $clog2(DEPTH+1)  words currently held in the FIFO, excluding the shifter.
- busy  output  1  shifter active or FIFO non-empty.

Behaviour:
- Reset (sampled on the clk edge while reset=1):
  - fifo_count=0, FIFO pointers=0, state=IDLE, bits_left=0.
  - outbits=IDLE_BIT, out_valid=0, busy=0.
  - in_ready=0 while reset is high; in_ready=1 on the first cycle after reset deasserts.
  - Reset mid-word discards the partial word and all buffered words; no further bits of them appear.
- Handshake:
  - in_ready = (fifo_count < DEPTH), decoded from registered count only. A pop in the same cycle does not raise in_ready.
  - A write occurs on an edge where in_valid && in_ready.
  - in_valid while in_ready=0 is ignored; the word is not captured, and the source must hold it.
- FIFO:
  - Circular buffer; write and read pointers wrap modulo DEPTH.
  - Simultaneous push and pop: count unchanged, and both operations take effect.
  - Pop occurs only on a shifter load, described below.
- Shifter FSM, states IDLE and SHIFT; transitions are evaluated only on edges with bit_en=1. With bit_en=0, shift register, bits_left, outbits, out_valid and state all hold.
  - IDLE, FIFO non-empty: pop the head into the shift register, drive its first bit (per MSB_FIRST) on outbits, out_valid=1, bits_left=DATA_W-1, go to SHIFT.
  - IDLE, FIFO empty: stay; outbits=IDLE_BIT, out_valid=0.
  - SHIFT, bits_left>0: drive the next bit, bits_left-1.
  - SHIFT, bits_left=0, FIFO non-empty: pop and load the next word; its first bit appears on this edge (gap-free). Stay in SHIFT.
  - SHIFT, bits_left=0, FIFO empty: go to IDLE; outbits=IDLE_BIT, out_valid=0.
- Latency: a word written on edge k into an empty, idle block has its first bit on outbits after the first edge j>k with bit_en=1 (j=k+1 when bit_en is held high).
- A word written on edge k is not visible to a pop on the same edge k; there is no fall-through.
- busy = (state==SHIFT) || (fifo_count!=0).

Test Plan:
- Reset, bit_en=1, push in_data=8'hB0 once → from next cycle outbits = 1,0,1,1,0,0,0,0 with out_valid=1 for 8 cycles, then outbits=0, out_valid=0, busy=0.
- Push 8'h5B then 8'hB5 on consecutive cycles, bit_en=1 → 16 contiguous valid bits 0101101110110101 with no idle bit between words; fifo_count peaks at 1.
- bit_en=0, push 5 words with in_valid held high → first 4 accepted, fifo_count=4, in_ready=0, 5th not captured. Raise bit_en → 5th accepted on the cycle after the first pop.
- bit_en toggled 1,0,1,0…, push 8'hB0 → each bit held for exactly 2 cycles; 16 cycles total of out_valid=1.
- Assert reset for 1 cycle after 3 bits of 8'hFF with 2 words queued → next cycle outbits=IDLE_BIT, out_valid=0, fifo_count=0, in_ready=1 one cycle after reset drops; no remaining bits emitted.
- MSB_FIRST=0, push 8'h0D → outbits = 1,0,1,1,0,0,0,0.
